seg7_rx_decoder: RTL and testbench

//  - Receive side of the 7-segment display interface: samples an active-low [0:6] segment bus.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_pattern_decode.sv | 45 ++++
 rtl/seg7_rx_decoder.sv | 171 +++++++++++++++++
 tb/tb_seg7_rx_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the 7-segment receive path.
//   - SEG_0..SEG_9, SEG_BLANK: active-low segment patterns, index 0 = segment a,
//     index 6 = segment g (a..g, [0:6]).
//   - state_t: handshake FSM states.
//   - STABLE_CYCLES_MIN/MAX: legal range of the stability filter length.
//   - CNT_W: width of the stability counter (covers STABLE_CYCLES_MAX-1).
package seg7_pkg;

  localparam logic [0:6] SEG_0     = 7'b000_0001;
  localparam logic [0:6] SEG_1     = 7'b100_1111;
  localparam logic [0:6] SEG_2     = 7'b001_0010;
  localparam logic [0:6] SEG_3     = 7'b000_0110;
  localparam logic [0:6] SEG_4     = 7'b100_1100;
  localparam logic [0:6] SEG_5     = 7'b010_0100;
  localparam logic [0:6] SEG_6     = 7'b010_0000;
  localparam logic [0:6] SEG_7     = 7'b000_1111;
  localparam logic [0:6] SEG_8     = 7'b000_0000;
  localparam logic [0:6] SEG_9     = 7'b000_1100;
  localparam logic [0:6] SEG_BLANK = 7'b111_1111;

  localparam int STABLE_CYCLES_MIN = 2;
  localparam int STABLE_CYCLES_MAX = 15;
  localparam int CNT_W             = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
//   Purely combinational map from an active-low a..g segment pattern to a BCD digit.
//   Ports:
//     pattern   in  [0:6]  segment pattern, active-low, index 0 = a
//     is_digit  out 1      pattern is one of the ten legal digits
//     is_blank  out 1      pattern is all segments off
//     digit     out 4      decoded digit (0 when not a digit)
//   is_digit=0 and is_blank=0 together mean the pattern is illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [0:6] pattern,
  output logic       is_digit,
  output logic       is_blank,
  output logic [3:0] digit
);

  // Pattern lookup; anything not listed falls through as illegal.
  always_comb begin
    is_digit = 1'b1;
    is_blank = 1'b0;
    digit    = 4'd0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default: begin
        is_digit = 1'b0;
        is_blank = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_rx_decoder.sv
// seg7_rx_decoder
//   Receive side of a 7-segment display link: registers the active-low a..g bus,
//   waits for STABLE_CYCLES identical samples, decodes the stable pattern and hands
//   each new digit out over valid/ready while keeping a DIGITS-deep BCD history.
//   Optional feature macro: SEG_ERR_COUNT_EN (adds the err_cnt port and counter).
//   Parameters:
//     STABLE_CYCLES  identical samples needed before a pattern is accepted (2..15)
//     DIGITS         BCD digits kept in history (>= 2)
//   Ports:
//     CLOCK_50   in   1          clock, rising edge
//     RESET      in   1          synchronous reset, active-high
//     seg_in     in   [0:6]      segment bus, active-low, a..g
//     dig_out    out  4          decoded digit
//     dig_valid  out  1          dig_out valid, held until accepted
//     dig_ready  in   1          consumer accept
//     blank      out  1          last accepted pattern was blank
//     seg_err    out  1          one-cycle pulse on an illegal accepted pattern
//     history    out  4*DIGITS   accepted digits, newest in [3:0]
//     err_cnt    out  8          saturating seg_err count (SEG_ERR_COUNT_EN only)
module seg7_rx_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [0:6]            seg_in,
  output logic [3:0]            dig_out,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic                  blank,
  output logic                  seg_err,
  output logic [4*DIGITS-1:0]   history
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [0:6]          samp_r;
  logic [0:6]          last_acc_r;
  logic [0:6]          last_acc_nxt_s;
  logic [CNT_W-1:0]    stab_cnt_r;
  state_t              state_r;
  state_t              state_nxt_s;
  logic                accept_s;
  logic                dec_is_digit_s;
  logic                dec_is_blank_s;
  logic [3:0]          dec_digit_s;
  logic [3:0]          dig_out_nxt_s;
  logic                dig_valid_nxt_s;
  logic                blank_nxt_s;
  logic                seg_err_nxt_s;
  logic [4*DIGITS-1:0] history_nxt_s;

  seg7_pattern_decode u_decode (
    .pattern  (samp_r),
    .is_digit (dec_is_digit_s),
    .is_blank (dec_is_blank_s),
    .digit    (dec_digit_s)
  );

  // Input register; resets to blank so a non-blank bus restarts the filter.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      samp_r <= SEG_BLANK;
    end else begin
      samp_r <= seg_in;
    end
  end

  // Stability counter: run length of identical samples, saturating.
  // It keeps counting during HOLD so a pattern that settled there is ready at once.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      stab_cnt_r <= {CNT_W{1'b0}};
    end else if (seg_in != samp_r) begin
      stab_cnt_r <= {CNT_W{1'b0}};
    end else if (stab_cnt_r != CNT_MAX) begin
      stab_cnt_r <= stab_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stab_cnt_r <= stab_cnt_r;
    end
  end

  // A settled pattern that differs from the last accepted one, seen only in IDLE.
  assign accept_s = (stab_cnt_r == CNT_MAX) && (samp_r != last_acc_r) && (state_r == IDLE);

  // Next-state and next-output logic for the handshake FSM.
  always_comb begin
    state_nxt_s     = state_r;
    last_acc_nxt_s  = last_acc_r;
    dig_out_nxt_s   = dig_out;
    dig_valid_nxt_s = dig_valid;
    blank_nxt_s     = blank;
    seg_err_nxt_s   = 1'b0;
    history_nxt_s   = history;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          last_acc_nxt_s = samp_r;
          if (dec_is_digit_s) begin
            dig_out_nxt_s   = dec_digit_s;
            dig_valid_nxt_s = 1'b1;
            blank_nxt_s     = 1'b0;
            history_nxt_s   = {history[4*DIGITS-5:0], dec_digit_s};
            state_nxt_s     = HOLD;
          end else if (dec_is_blank_s) begin
            blank_nxt_s = 1'b1;
          end else begin
            seg_err_nxt_s = 1'b1;
            blank_nxt_s   = 1'b0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (dig_valid && dig_ready) begin
          dig_valid_nxt_s = 1'b0;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        // Unreachable encoding: drop any pending digit and recover to IDLE.
        dig_valid_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
  end

  // FSM state, accepted-pattern memory and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_r    <= IDLE;
      last_acc_r <= SEG_BLANK;
      dig_out    <= 4'd0;
      dig_valid  <= 1'b0;
      blank      <= 1'b1;
      seg_err    <= 1'b0;
      history    <= {(4*DIGITS){1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      last_acc_r <= last_acc_nxt_s;
      dig_out    <= dig_out_nxt_s;
      dig_valid  <= dig_valid_nxt_s;
      blank      <= blank_nxt_s;
      seg_err    <= seg_err_nxt_s;
      history    <= history_nxt_s;
    end
  end

`ifdef SEG_ERR_COUNT_EN
  // Saturating count of illegal-pattern events, stepped with each seg_err pulse.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      err_cnt <= 8'd0;
    end else if (seg_err_nxt_s && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// tb_seg7_rx_decoder
//   Self-checking bench for seg7_rx_decoder. A reference model keeps a sliding
//   window of the last STABLE_CYCLES bus samples and applies the acceptance and
//   handshake rules directly; every cycle the DUT outputs are compared with it.
//   Directed scenarios are followed by a randomized phase.
//   Honours SEG_ERR_COUNT_EN (err_cnt checked when defined).
module tb_seg7_rx_decoder;

  localparam int S      = 4;
  localparam int DIGITS = 4;

  logic               CLOCK_50 = 1'b0;
  logic               RESET;
  logic [0:6]         seg_in;
  logic [3:0]         dig_out;
  logic               dig_valid;
  logic               dig_ready;
  logic               blank;
  logic               seg_err;
  logic [4*DIGITS-1:0] history;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0]         err_cnt;
`endif

  seg7_rx_decoder #(.STABLE_CYCLES(S), .DIGITS(DIGITS)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .seg_in    (seg_in),
    .dig_out   (dig_out),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .blank     (blank),
    .seg_err   (seg_err),
    .history   (history)
`ifdef SEG_ERR_COUNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Digit patterns written out independently of the RTL package.
  logic [0:6] pat_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};
  localparam logic [0:6] BLANK_PAT = 7'b1111111;
  localparam logic [0:6] ILLEGAL_PAT = 7'b1110000;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [0:6]          win [$];
  logic [0:6]          m_last  = BLANK_PAT;
  bit                  m_busy  = 1'b0;
  logic [3:0]          m_dig   = 4'd0;
  logic                m_valid = 1'b0;
  logic                m_blank = 1'b1;
  logic                m_err   = 1'b0;
  logic [4*DIGITS-1:0] m_hist  = '0;
  int                  m_ecnt  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [0:6] p);
    for (int i = 0; i < 10; i++) begin
      if (pat_tab[i] == p) return i;
    end
    return -1;
  endfunction

  // Model update for one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    int  d;
    bit  uniform;
    if (RESET) begin
      win.delete();
      m_last = BLANK_PAT; m_busy = 1'b0; m_dig = 4'd0; m_valid = 1'b0;
      m_blank = 1'b1; m_err = 1'b0; m_hist = '0; m_ecnt = 0;
    end else begin
      m_err = 1'b0;
      if (m_busy) begin
        if (dig_ready) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
        end
      end else if (win.size() == S) begin
        uniform = 1'b1;
        for (int i = 1; i < S; i++) if (win[i] != win[0]) uniform = 1'b0;
        if (uniform && win[0] != m_last) begin
          m_last = win[0];
          d = lookup(win[0]);
          if (d >= 0) begin
            m_dig = d[3:0]; m_valid = 1'b1; m_busy = 1'b1; m_blank = 1'b0;
            m_hist = {m_hist[4*DIGITS-5:0], d[3:0]};
          end else if (win[0] == BLANK_PAT) begin
            m_blank = 1'b1;
          end else begin
            m_err = 1'b1; m_blank = 1'b0;
            if (m_ecnt < 255) m_ecnt++;
          end
        end
      end
      win.push_back(seg_in);
      if (win.size() > S) void'(win.pop_front());
    end
  endtask

  task automatic check_all();
    check_val("dig_valid", 32'(dig_valid), 32'(m_valid));
    check_val("dig_out",   32'(dig_out),   32'(m_dig));
    check_val("blank",     32'(blank),     32'(m_blank));
    check_val("seg_err",   32'(seg_err),   32'(m_err));
    check_val("history",   32'(history),   32'(m_hist));
`ifdef SEG_ERR_COUNT_EN
    check_val("err_cnt",   32'(err_cnt),   32'(m_ecnt));
`endif
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_edge();
    @(negedge CLOCK_50);
    check_all();
  endtask

  initial begin
    RESET = 1'b1; seg_in = BLANK_PAT; dig_ready = 1'b0;
    repeat (3) tick();
    check_val("rst_valid", 32'(dig_valid), 32'd0);
    check_val("rst_blank", 32'(blank), 32'd1);
    RESET = 1'b0;

    // Idle on blank
    repeat (20) tick();
    check_val("idle_blank", 32'(blank), 32'd1);
    check_val("idle_valid", 32'(dig_valid), 32'd0);
    check_val("idle_err",   32'(seg_err), 32'd0);
    check_val("idle_hist",  32'(history), 32'd0);

    // Digit 3 with ready high: valid exactly on edge k+S for one cycle
    seg_in = pat_tab[3]; dig_ready = 1'b1;
    repeat (S) tick();
    check_val("d3_early", 32'(dig_valid), 32'd0);
    tick();
    check_val("d3_valid", 32'(dig_valid), 32'd1);
    check_val("d3_digit", 32'(dig_out), 32'd3);
    tick();
    check_val("d3_drop",  32'(dig_valid), 32'd0);
    check_val("d3_hist",  32'(history[3:0]), 32'd3);

    // Digit 4 held without ready
    dig_ready = 1'b0; seg_in = pat_tab[4];
    repeat (S + 1) tick();
    repeat (10) tick();
    check_val("d4_held",  32'(dig_valid), 32'd1);
    check_val("d4_digit", 32'(dig_out), 32'd4);
    dig_ready = 1'b1;
    tick();
    check_val("d4_drop",  32'(dig_valid), 32'd0);
    dig_ready = 1'b0;

    // Change 7 -> 9 during HOLD
    seg_in = pat_tab[7];
    repeat (S + 1) tick();
    check_val("d7_digit", 32'(dig_out), 32'd7);
    seg_in = pat_tab[9];
    repeat (8) tick();
    check_val("d7_still", 32'(dig_out), 32'd7);
    dig_ready = 1'b1;
    tick();
    check_val("d7_drop",  32'(dig_valid), 32'd0);
    tick();
    check_val("d9_valid", 32'(dig_valid), 32'd1);
    check_val("d9_digit", 32'(dig_out), 32'd9);
    check_val("d79_hist", 32'(history[7:0]), 32'h79);
    tick();

    // One-cycle glitch: no event
    seg_in = pat_tab[8];
    tick();
    seg_in = pat_tab[9];
    repeat (8) tick();
    check_val("glitch_valid", 32'(dig_valid), 32'd0);
    check_val("glitch_hist",  32'(history), 32'h3479);

    // Illegal pattern held S cycles
    seg_in = ILLEGAL_PAT;
    repeat (S) tick();
    check_val("ill_early", 32'(seg_err), 32'd0);
    tick();
    check_val("ill_pulse", 32'(seg_err), 32'd1);
    check_val("ill_hist",  32'(history), 32'h3479);
    check_val("ill_blank", 32'(blank), 32'd0);
`ifdef SEG_ERR_COUNT_EN
    check_val("ill_cnt",   32'(err_cnt), 32'd1);
`endif
    tick();
    check_val("ill_clear", 32'(seg_err), 32'd0);

    // Reset while holding digit 5
    dig_ready = 1'b0; seg_in = pat_tab[5];
    repeat (S + 1) tick();
    check_val("d5_digit", 32'(dig_out), 32'd5);
    RESET = 1'b1;
    tick();
    check_val("rh_valid", 32'(dig_valid), 32'd0);
    check_val("rh_hist",  32'(history), 32'd0);
    check_val("rh_blank", 32'(blank), 32'd1);
    RESET = 1'b0;
    repeat (S) tick();
    check_val("rh_early", 32'(dig_valid), 32'd0);
    tick();
    check_val("rh_reacc", 32'(dig_valid), 32'd1);
    check_val("rh_digit", 32'(dig_out), 32'd5);

    // Randomized phase
    for (int seg = 0; seg < 300; seg++) begin
      int sel;
      int dur;
      sel = $urandom_range(0, 15);
      if (sel < 10)      seg_in = pat_tab[sel];
      else if (sel < 12) seg_in = BLANK_PAT;
      else               seg_in = 7'($urandom);
      dur = $urandom_range(1, 8);
      for (int c = 0; c < dur; c++) begin
        dig_ready = ($urandom_range(0, 3) != 0);
        RESET     = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    RESET = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
